// File: rtl/shift_ctrl_pkg.sv
// ============================================================================
//  Module      : shift_ctrl_pkg
//  Description : Shared state encoding and line constants for the serial
//                transmit sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 4'b0001,
        ST_SHIFT = 4'b0010,
        ST_PAR   = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ff_d_bank.sv
// ============================================================================
//  Module      : ff_d_bank
//  Description : Bank of D flip-flops with synchronous reset, parallel load
//                and right-shift enable; q[0] is the serial end of the bank.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ff_d_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load wins over shift so a restart never sees a half-shifted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift_en) begin
            q <= q >> 1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_reg_ctrl.sv
// ============================================================================
//  Module      : shift_reg_ctrl
//  Description : LSB-first serial transmit sequencer driving one ff_d_bank.
//                Optional even-parity bit enabled by `define SHIFT_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             sout,
    output logic [CW-1:0]    bit_cnt
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state;
    state_t             state_nxt;
    logic               load;
    logic               shift_en;
    logic               sout_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic [WIDTH-1:0]   sreg_q;

    ff_d_bank #(
        .WIDTH (WIDTH)
    ) sreg (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift_en (shift_en),
        .d        (din),
        .q        (sreg_q)
    );

`ifdef SHIFT_PARITY_EN
    logic par_bit;
    logic par_now;

    // The first SHIFT cycle still holds the untouched captured word.
    assign par_now = (bit_cnt == '0) ? ^sreg_q : par_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bit <= 1'b0;
        end else if (state == ST_SHIFT && bit_cnt == '0) begin
            par_bit <= ^sreg_q;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sout    <= LINE_IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sout    <= sout_nxt;
            bit_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        sout_nxt  = sout;
        cnt_nxt   = bit_cnt;
        unique case (state)
            ST_IDLE: begin
                sout_nxt = LINE_IDLE;
                if (start) begin
                    load      = 1'b1;
                    cnt_nxt   = '0;
                    sout_nxt  = din[0];
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                cnt_nxt  = bit_cnt + CW'(1);
                if (bit_cnt == CNT_LAST) begin
`ifdef SHIFT_PARITY_EN
                    sout_nxt  = par_now;
                    state_nxt = ST_PAR;
`else
                    sout_nxt  = LINE_IDLE;
                    state_nxt = ST_DONE;
`endif
                end else begin
                    // Bit that sits in q[0] once this edge's shift completes.
                    sout_nxt = 1'(sreg_q >> 1);
                end
            end
`ifdef SHIFT_PARITY_EN
            ST_PAR: begin
                cnt_nxt   = bit_cnt + CW'(1);
                sout_nxt  = LINE_IDLE;
                state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                sout_nxt  = LINE_IDLE;
                state_nxt = ST_IDLE;
            end
            default: begin
                sout_nxt  = LINE_IDLE;
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign ready = (state == ST_IDLE);
    assign busy  = (state == ST_SHIFT) || (state == ST_PAR);
    assign done  = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_ctrl.sv
// ============================================================================
//  Module      : tb_shift_reg_ctrl
//  Description : Scoreboard bench for shift_reg_ctrl (WIDTH=8); frames are
//                collected from sout while busy and checked on each done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_ctrl;

    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 2);
`ifdef SHIFT_PARITY_EN
    localparam int LAT   = WIDTH + 1;
`else
    localparam int LAT   = WIDTH;
`endif

    typedef struct {
        logic [31:0] frame;
        int          done_cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [7:0]    din;
    logic          ready;
    logic          busy;
    logic          done;
    logic          sout;
    logic [CW-1:0] bit_cnt;

    exp_t          exp_q[$];
    int            cyc;
    int            n_checks;
    int            n_fail;
    int            nbits;
    logic [31:0]   got;

    shift_reg_ctrl #(
        .WIDTH (WIDTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din     (din),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .sout    (sout),
        .bit_cnt (bit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: rebuild each frame from sout and score it when done appears.
    always @(negedge clk) begin
        if (rst || ready) begin
            nbits = 0;
            got   = '0;
        end else if (busy) begin
            if (nbits < 32) got[nbits] = sout;
            nbits++;
        end
        if (done && !rst) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_bits",  got,           e.frame);
                check("frame_len",   32'(nbits),    32'(LAT));
                check("done_cycle",  32'(cyc),      32'(e.done_cyc));
                check("done_bitcnt", 32'(bit_cnt),  32'(LAT));
                check("done_sout",   32'(sout),     32'd1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] d, input logic par, input bit push, output int e0);
        int   t;
        exp_t e;
        t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("send_ready_wait", 32'(ready), 32'd1);
        start = 1'b1;
        din   = d;
        e0    = cyc + 1;
`ifdef SHIFT_PARITY_EN
        e.frame = {23'd0, par, d};
`else
        e.frame = {24'd0, d};
        if (par) e.frame = e.frame;
`endif
        e.done_cyc = e0 + LAT;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        din   = ~d;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait_budget", 32'(t < 200), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",  32'(ready),   32'd1);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_done",   32'(done),    32'd0);
        check("rst_sout",   32'(sout),    32'd1);
        check("rst_bitcnt", 32'(bit_cnt), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // A5 -> sout 1,0,1,0,0,1,0,1; even parity 0.
        send(8'hA5, 1'b0, 1'b1, e0);
        check("shift_busy", 32'(busy), 32'd1);
        wait_idle();

        // Start pulsed at E0+3 is ignored.
        send(8'h3C, 1'b0, 1'b1, e0);
        while (cyc < e0 + 2) @(negedge clk);
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Reset at E0+4 aborts the FF transfer without a done pulse.
        send(8'hFF, 1'b0, 1'b0, e0);
        while (cyc < e0 + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_sout",   32'(sout),    32'd1);
        check("abort_busy",   32'(busy),    32'd0);
        check("abort_done",   32'(done),    32'd0);
        check("abort_bitcnt", 32'(bit_cnt), 32'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        send(8'h01, 1'b1, 1'b1, e0);
        wait_idle();

        // start held high with 81: two frames, one idle cycle between.
        begin
            exp_t e;
            start = 1'b1;
            din   = 8'h81;
            e0    = cyc + 1;
            e.frame    = 32'h81;
            e.done_cyc = e0 + LAT;
            exp_q.push_back(e);
            e.done_cyc = e0 + LAT + 2 + LAT;
            exp_q.push_back(e);
            while (cyc < e0 + LAT + 1) @(negedge clk);
            check("gap_ready", 32'(ready), 32'd1);
            check("gap_sout",  32'(sout),  32'd1);
            @(negedge clk);
            check("restart_busy", 32'(busy), 32'd1);
            start = 1'b0;
            din   = 8'h00;
            wait_idle();
        end

`ifdef SHIFT_PARITY_EN
        send(8'h07, 1'b1, 1'b1, e0);
        wait_idle();
        send(8'h03, 1'b0, 1'b1, e0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
